// File: rtl/keccak_squeeze.sv
// Squeeze end of the Keccak sponge: captures a permuted state and streams its
// rate lanes as 64-bit words, requesting further permutations for long digests.
module keccak_squeeze #(
    parameter int RATE_LANES = 17,
    parameter int OUT_LANES  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1599:0] state_in,
    input  logic          state_valid,
    output logic          state_ready,
    output logic          perm_req,
    output logic [63:0]   dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          dout_last,
    output logic          busy
);

    localparam int WW = $clog2(OUT_LANES + 1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_STREAM    = 2'd1;
    localparam logic [1:0] S_WAIT_PERM = 2'd2;

    localparam logic [4:0]    LAST_LANE = 5'(RATE_LANES - 1);
    localparam logic [WW-1:0] LAST_WORD = WW'(OUT_LANES - 1);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never depends on ready, and a stalled word is held.
    logic [1:0]    fsm;
    logic [1599:0] st_reg;
    logic [4:0]    lane_cnt;
    logic [WW-1:0] word_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm      <= S_IDLE;
            st_reg   <= '0;
            lane_cnt <= '0;
            word_cnt <= '0;
        end else begin
            case (fsm)
                S_IDLE: begin
                    if (state_valid) begin
                        st_reg   <= state_in;
                        lane_cnt <= '0;
                        word_cnt <= '0;
                        fsm      <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    // Digest end wins over the rate boundary: no extra permutation.
                    if (dout_ready) begin
                        if (word_cnt == LAST_WORD) begin
                            fsm <= S_IDLE;
                        end else if (lane_cnt == LAST_LANE) begin
                            word_cnt <= word_cnt + WW'(1);
                            fsm      <= S_WAIT_PERM;
                        end else begin
                            lane_cnt <= lane_cnt + 5'd1;
                            word_cnt <= word_cnt + WW'(1);
                        end
                    end
                end
                S_WAIT_PERM: begin
                    // word_cnt carries on across permutations.
                    if (state_valid) begin
                        st_reg   <= state_in;
                        lane_cnt <= '0;
                        fsm      <= S_STREAM;
                    end
                end
                default: fsm <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        state_ready = (fsm == S_IDLE) || (fsm == S_WAIT_PERM);
        perm_req    = (fsm == S_WAIT_PERM);
        busy        = (fsm != S_IDLE);
        dout_valid  = (fsm == S_STREAM);
        dout_last   = dout_valid && (word_cnt == LAST_WORD);
        dout        = '0;
        if (dout_valid) begin
            dout = st_reg[{lane_cnt, 6'd0} +: 64];
        end
    end

endmodule

// File: tb/tb_keccak_squeeze.sv
// Bench for keccak_squeeze: four instances with different rate/digest sizes,
// driven from a vector table and random runs, checked against a word-list model.
module tb_keccak_squeeze;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [1599:0] st_in [4];
    logic          sv [4];
    logic          dr [4];
    logic          sr [4];
    logic          pr [4];
    logic          dv [4];
    logic          dl [4];
    logic          bz [4];
    logic [63:0]   dw [4];

    int out_of  [4] = '{4, 20, 17, 7};
    int rate_of [4] = '{17, 17, 17, 3};
    int pat     [7] = '{1, 0, 0, 1, 0, 1, 1};

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int R = (g == 3) ? 3 : 17;
        localparam int O = (g == 0) ? 4 : (g == 1) ? 20 : (g == 2) ? 17 : 7;
        keccak_squeeze #(.RATE_LANES(R), .OUT_LANES(O)) u_dut (
            .clk(clk), .rst_n(rst_n), .state_in(st_in[g]), .state_valid(sv[g]),
            .state_ready(sr[g]), .perm_req(pr[g]), .dout(dw[g]), .dout_valid(dv[g]),
            .dout_ready(dr[g]), .dout_last(dl[g]), .busy(bz[g])
        );
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag, input int i);
        chk({tag, ".dout"}, dw[i], 64'd0);
        chk({tag, ".dout_valid"}, 64'(dv[i]), 64'd0);
        chk({tag, ".dout_last"}, 64'(dl[i]), 64'd0);
        chk({tag, ".perm_req"}, 64'(pr[i]), 64'd0);
        chk({tag, ".busy"}, 64'(bz[i]), 64'd0);
        chk({tag, ".state_ready"}, 64'(sr[i]), 64'd1);
    endtask

    typedef struct {
        int inst;
        int stall_pct;
        int perm_delay;
        int inject_pct;
        bit rand_data;
        bit use_pat;
        int abort_at;
        int exp_hs;
        int exp_perms;
    } vec_t;

    // Model: the digest is the concatenation of the rate lanes of successive
    // states; phase 0 idle-before, 1 streaming, 2 awaiting a new state, 3 done.
    task automatic run_vec(input int vn, input vec_t v);
        int i, out, rate, nst, phase, popped, hs, perms, wait_cnt, pat_idx;
        bit prev_pr, done;
        string t;
        logic [1599:0] sts [8];
        logic [63:0] exp_q [$];
        logic [63:0] w;
        i = v.inst; out = out_of[i]; rate = rate_of[i];
        nst = (out + rate - 1) / rate;
        t = $sformatf("v%0d.i%0d", vn, i);
        for (int s = 0; s < nst; s++)
            for (int k = 0; k < 25; k++) begin
                w = v.rand_data ? {$urandom, $urandom} : 64'(s * 256 + k);
                sts[s][64*k +: 64] = w;
            end
        for (int wd = 0; wd < out; wd++) exp_q.push_back(sts[wd / rate][64*(wd % rate) +: 64]);
        phase = 0; popped = 0; hs = 0; perms = 0; wait_cnt = 0; pat_idx = 0;
        prev_pr = 1'b0; done = 1'b0;
        for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
            @(negedge clk);
            chk({t, ".busy"}, 64'(bz[i]), 64'(phase == 1 || phase == 2));
            chk({t, ".state_ready"}, 64'(sr[i]), 64'(phase != 1));
            chk({t, ".perm_req"}, 64'(pr[i]), 64'(phase == 2));
            chk({t, ".dout_valid"}, 64'(dv[i]), 64'(phase == 1));
            if (phase == 1 && exp_q.size() > 0) begin
                chk($sformatf("%s.dout[w%0d]", t, popped), dw[i], exp_q[0]);
                chk($sformatf("%s.dout_last[w%0d]", t, popped), 64'(dl[i]), 64'(exp_q.size() == 1));
            end else if (phase == 2) begin
                chk({t, ".dout_last_wait"}, 64'(dl[i]), 64'd0);
            end
            if (pr[i] && !prev_pr) perms++;
            prev_pr = pr[i];
            if (v.abort_at >= 0 && popped == v.abort_at && (phase == 1 || phase == 2)) begin
                rst_n = 1'b0;
                #1;
                chk_reset_vals({t, ".rst"}, i);
                sv[i] = 1'b0; dr[i] = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                done = 1'b1;
            end else begin
                case (phase)
                    0: begin
                        sv[i] = 1'b1; st_in[i] = sts[0]; phase = 1;
                    end
                    1: begin
                        dr[i] = v.use_pat ? (pat[pat_idx % 7] != 0) : ($urandom_range(99) >= v.stall_pct);
                        pat_idx++;
                        if (v.inject_pct > 0 && $urandom_range(99) < v.inject_pct) begin
                            sv[i] = 1'b1; st_in[i] = ~sts[0];
                        end else begin
                            sv[i] = 1'b0;
                        end
                        if (dr[i]) begin
                            void'(exp_q.pop_front());
                            popped++; hs++;
                            if (popped == out) phase = 3;
                            else if (popped % rate == 0) begin phase = 2; wait_cnt = 0; end
                        end
                    end
                    2: begin
                        dr[i] = ($urandom_range(1) == 1);
                        if (wait_cnt >= v.perm_delay) begin
                            sv[i] = 1'b1; st_in[i] = sts[popped / rate]; phase = 1;
                        end else begin
                            sv[i] = 1'b0; wait_cnt++;
                        end
                    end
                    default: begin
                        sv[i] = 1'b0; dr[i] = 1'b0; done = 1'b1;
                    end
                endcase
            end
        end
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL %s.timeout: got no digest end expected end within budget", t);
        end
        chk({t, ".handshakes"}, 64'(hs), 64'(v.exp_hs));
        chk({t, ".perm_rises"}, 64'(perms), 64'(v.exp_perms));
        if (v.abort_at < 0) chk({t, ".leftover"}, 64'(exp_q.size()), 64'd0);
        sv[i] = 1'b0; dr[i] = 1'b0;
    endtask

    initial begin
        vec_t vecs [11];
        vec_t rv;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            st_in[i] = '0; sv[i] = 1'b0; dr[i] = 1'b0;
        end
        //          inst stall dly inj rnd pat abort hs perms
        vecs[0]  = '{0, 0,  0, 0,   0, 0, -1,  4, 0};
        vecs[1]  = '{0, 0,  0, 0,   0, 1, -1,  4, 0};
        vecs[2]  = '{1, 0,  5, 0,   0, 0, -1, 20, 1};
        vecs[3]  = '{2, 0,  0, 0,   0, 0, -1, 17, 0};
        vecs[4]  = '{0, 0,  0, 100, 0, 0, -1,  4, 0};
        vecs[5]  = '{0, 0,  0, 0,   0, 0,  2,  2, 0};
        vecs[6]  = '{0, 0,  0, 0,   0, 0, -1,  4, 0};
        vecs[7]  = '{1, 0,  3, 0,   0, 0, 17, 17, 1};
        vecs[8]  = '{1, 30, 2, 50,  0, 0, -1, 20, 1};
        vecs[9]  = '{3, 0,  0, 0,   0, 0, -1,  7, 2};
        vecs[10] = '{3, 40, 1, 30,  1, 0, -1,  7, 2};

        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) chk_reset_vals($sformatf("reset.i%0d", i), i);
        rst_n = 1'b1;

        for (int n = 0; n < 11; n++) run_vec(n, vecs[n]);

        for (int n = 0; n < 12; n++) begin
            rv.inst       = $urandom_range(3);
            rv.stall_pct  = $urandom_range(60);
            rv.perm_delay = $urandom_range(4);
            rv.inject_pct = $urandom_range(30);
            rv.rand_data  = 1'b1;
            rv.use_pat    = 1'b0;
            rv.abort_at   = -1;
            rv.exp_hs     = out_of[rv.inst];
            rv.exp_perms  = (out_of[rv.inst] - 1) / rate_of[rv.inst];
            run_vec(100 + n, rv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/keccak_squeeze.md
Name: keccak_squeeze

Overview:
- Output (squeeze) end of the Keccak sponge.
- Captures the 1600-bit permuted state produced by the round/permutation core.
- Streams the rate lanes out as 64-bit words on a valid/ready interface.
- When the digest is longer than the rate (XOF / SHAKE), it requests another permutation and resumes streaming from the new state.

Parameters:
RATE_LANES, 17, number of 64-bit rate lanes readable per state (17 = SHA3-256; legal 1..25)
OUT_LANES, 4, total 64-bit output words per digest (legal >= 1, may exceed RATE_LANES)

Ports:
clk  input  1  clock, all flops rising-edge
rst_n  input  1  asynchronous active-low reset
state_in  input  1600  permuted state; lane k = state_in[64k+63:64k], k = x + 5y (lane 0 = bits 63:0)
state_valid  input  1  state_in valid
state_ready  output  1  block accepts state_in this cycle
perm_req  output  1  request one more permutation of the current sponge state (level)
dout  output  64  output lane
dout_valid  output  1  dout valid
dout_ready  input  1  downstream accepts dout
dout_last  output  1  marks final word of the digest
busy  output  1  high in any state other than IDLE

Behaviour:
- FSM states: IDLE, STREAM, WAIT_PERM. Reset (async, rst_n=0) forces IDLE and clears all registers.
- Reset output values: dout=0, dout_valid=0, dout_last=0, perm_req=0, busy=0. state_ready=1 (decoded from IDLE).
- Registers:
  - st_reg[1599:0] holds the captured state.
  - lane_cnt is 5 bits, 0..RATE_LANES-1.
  - word_cnt has width $clog2(OUT_LANES+1), 0..OUT_LANES-1.
- state_ready = (fsm==IDLE) | (fsm==WAIT_PERM); it is 0 in STREAM.
- state_valid while state_ready=0 is ignored; st_reg is unchanged.
- IDLE: on state_valid & state_ready, capture st_reg<=state_in, lane_cnt<=0, word_cnt<=0, go to STREAM. Capture at edge T gives dout_valid=1 from T+1 (1-cycle latency).
- STREAM:
  - Outputs: dout = st_reg lane[lane_cnt] (mux of registers), dout_valid=1, dout_last=(word_cnt==OUT_LANES-1).
  - dout and dout_last are held stable while dout_valid & !dout_ready.
  - On handshake (dout_valid & dout_ready):
    - dout_last=1: go to IDLE. dout_valid drops the next cycle and st_reg is left as is.
    - else if lane_cnt==RATE_LANES-1: word_cnt++, go to WAIT_PERM.
    - else: lane_cnt++, word_cnt++.
- WAIT_PERM:
  - Outputs: perm_req=1, dout_valid=0, dout_last=0.
  - On state_valid: capture st_reg<=state_in, lane_cnt<=0, go to STREAM. word_cnt is preserved. perm_req falls in the same cycle the new state is accepted (combinational from FSM state).
- perm_req is 0 in IDLE and STREAM.
- Rate boundary and digest end on the same word: OUT_LANES a multiple of RATE_LANES means the last word sits at lane RATE_LANES-1. dout_last takes priority: go to IDLE, no perm_req.
- Capacity lanes (index >= RATE_LANES) are never output.
- Reset mid-operation: any state returns to IDLE immediately. A pending perm_req drops asynchronously and partial digest progress is discarded.
- No combinational path from dout_ready to dout_valid or dout.

Test Plan:
1. Defaults; state lane k = 64'h0000_0000_0000_00kk; state_valid 1 cycle, dout_ready=1 -> dout 0,1,2,3 on 4 consecutive cycles starting 1 cycle after capture; dout_last only on 3; busy falls after; perm_req never asserts.
2. Backpressure: same state, dout_ready toggling 1,0,0,1,0,1,1 -> dout values held while stalled; exactly 4 handshakes carrying 0,1,2,3; no duplicates or drops.
3. XOF, OUT_LANES=20, RATE_LANES=17: first state lanes k, second state lanes 0x100+k.
   - After lane 16 handshake, perm_req=1 and dout_valid=0.
   - Supply second state after 5 cycles -> dout 0x100,0x101,0x102, last on 0x102. Total 20 words.
4. Exact-multiple boundary, OUT_LANES=17 -> word 16 has dout_last=1; FSM returns to IDLE; perm_req stays 0.
5. state_valid with a different state during STREAM -> ignored (state_ready=0); output sequence unchanged.
6. rst_n low after 2nd word of case 1 (and separately during WAIT_PERM in case 3) -> outputs at reset values immediately. After release, a new state streams from lane 0 with word count restarted.
